// File: rtl/cordic_wrapper.sv
// Byte-serial CORDIC vectoring engine on a TinyTapeout-style pin interface:
// four input bytes (X,Y) in, six bytes (gain-compensated magnitude, BAM phase) out.
module cordic_wrapper #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Four fractional LSBs keep shift truncation well inside the magnitude error budget.
  localparam int FRAC  = 4;
  localparam int DW    = WIDTH + GUARD + FRAC;
  localparam int CW    = $clog2(ITER + 1);
  localparam int PW    = DW + 15;
  localparam int SHIFT = 15 + FRAC;

  localparam logic [1:0]  S_RX   = 2'd0;
  localparam logic [1:0]  S_CALC = 2'd1;
  localparam logic [1:0]  S_GAIN = 2'd2;
  localparam logic [1:0]  S_TX   = 2'd3;
  localparam logic [14:0] GAIN_K = 15'h4DBA;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [23:0]          buf_q, buf_d;
  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic [31:0]          z_q, z_d;
  logic                 zero_q, zero_d;
  logic [47:0]          tx_q, tx_d;

  logic in_valid, out_ready, in_ready, out_valid, in_beat, out_beat;

  // Handshake: a beat is valid & ready sampled at a rising clk edge; ready/valid drop while ena=0.
  assign in_valid  = uio_in[0];
  assign out_ready = uio_in[3];
  assign in_ready  = ena & ~rst_n & (state_q == S_RX);
  assign out_valid = ena & (state_q == S_TX);
  assign in_beat   = in_valid & in_ready;
  assign out_beat  = out_valid & out_ready;

  assign uo_out  = (state_q == S_TX) ? tx_q[7:0] : 8'h00;
  assign uio_out = {5'b0_0000, out_valid, in_ready, 1'b0};
  assign uio_oe  = 8'b0000_0110;

  logic [WIDTH-1:0] x_in, y_in;
  logic [DW-1:0]    x_ext, y_ext;

  assign x_in  = buf_q[15:0];
  assign y_in  = {ui_in, buf_q[23:16]};
  assign x_ext = {{GUARD{x_in[WIDTH-1]}}, x_in, {FRAC{1'b0}}};
  assign y_ext = {{GUARD{y_in[WIDTH-1]}}, y_in, {FRAC{1'b0}}};

  // Counter value 0 in CALC is the pre-rotation step, values 1..ITER are micro-rotations.
  logic [CW-1:0]        it_idx;
  logic signed [DW-1:0] x_sh, y_sh;
  logic [31:0]          atan_v;

  assign it_idx = cnt_q - CW'(1);
  assign x_sh   = x_q >>> it_idx;
  assign y_sh   = y_q >>> it_idx;
  assign atan_v = atan_bam(it_idx);

  function automatic logic [31:0] atan_bam(input logic [CW-1:0] i);
    logic [31:0] a;
    case (int'(i))
      0:       a = 32'h2000_0000;
      1:       a = 32'h12E4_051D;
      2:       a = 32'h09FB_385B;
      3:       a = 32'h0511_11D4;
      4:       a = 32'h028B_0D43;
      5:       a = 32'h0145_D7E1;
      6:       a = 32'h00A2_F61E;
      7:       a = 32'h0051_7C55;
      8:       a = 32'h0028_BE53;
      9:       a = 32'h0014_5F2F;
      10:      a = 32'h000A_2F98;
      11:      a = 32'h0005_17CC;
      12:      a = 32'h0002_8BE6;
      13:      a = 32'h0001_45F3;
      14:      a = 32'h0000_A2FA;
      15:      a = 32'h0000_517D;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

  // Gain compensation with round-to-nearest, then saturation to 16 bits.
  logic [DW-1:0]          x_pos;
  logic [PW-1:0]          prod, prod_r;
  logic [WIDTH+GUARD-1:0] scaled;
  logic [15:0]            mag;
  logic [31:0]            phase;

  assign x_pos  = x_q[DW-1] ? '0 : x_q;
  assign prod   = PW'(x_pos) * PW'(GAIN_K);
  assign prod_r = prod + (PW'(1) << (SHIFT - 1));
  assign scaled = prod_r[PW-1:SHIFT];
  assign mag    = (|scaled[WIDTH+GUARD-1:16]) ? 16'hFFFF : scaled[15:0];
  assign phase  = zero_q ? 32'h0000_0000 : z_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, uio_in[7:4], uio_in[2:1], prod_r[SHIFT-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    tx_d    = tx_q;
    if (ena) begin
      case (state_q)
        S_RX: begin
          if (in_beat) begin
            buf_d = {ui_in, buf_q[23:8]};
            if (cnt_q == CW'(3)) begin
              x_d     = x_ext;
              y_d     = y_ext;
              z_d     = 32'h0000_0000;
              zero_d  = (x_in == '0) && (y_in == '0);
              cnt_d   = '0;
              state_d = S_CALC;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            if (x_q < 0) begin
              x_d = -x_q;
              y_d = -y_q;
              z_d = 32'h8000_0000;
            end
          end else if (y_q >= 0) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_v;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_v;
          end
          if (cnt_q == CW'(ITER)) begin
            cnt_d   = '0;
            state_d = S_GAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_GAIN: begin
          tx_d    = {phase, mag};
          cnt_d   = '0;
          state_d = S_TX;
        end
        S_TX: begin
          if (out_beat) begin
            tx_d = {8'h00, tx_q[47:8]};
            if (cnt_q == CW'(5)) begin
              cnt_d   = '0;
              state_d = S_RX;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_RX;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_RX;
      cnt_q   <= '0;
      buf_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_cordic_wrapper.sv
// Directed bench for cordic_wrapper: hand-computed magnitude/phase vectors,
// latency, backpressure, ignored strobes, reset abort and ena freeze.
module tb_cordic_wrapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mag_exp_q[$];
  logic [31:0] ph_exp_q[$];

  cordic_wrapper dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int unsigned tol);
    logic signed [31:0] diff;
    logic [31:0]        adiff;
    n_checks++;
    diff  = $signed(got - exp);
    adiff = (diff < 0) ? 32'(-diff) : 32'(diff);
    if (adiff > tol) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    ui_in     = b;
    uio_in[0] = 1'b1;
    while (!uio_out[1] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_for_byte", 32'(uio_out[1]), 32'd1, 0);
    @(posedge clk);
    @(negedge clk);
    uio_in[0] = 1'b0;
    ui_in     = 8'h00;
  endtask

  task automatic recv(input string tag, input int unsigned mtol, input int unsigned ptol,
                      input bit bp, input bit poke);
    logic [7:0]  b[6];
    logic [31:0] mag_e, ph_e, got_mag, got_ph;
    logic [7:0]  first;
    int w, vcnt, changes;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!uio_out[2] && w < 50) begin
        @(negedge clk);
        w++;
      end
      check({tag, "_out_valid"}, 32'(uio_out[2]), 32'd1, 0);
      if (poke) begin
        uio_in[0] = 1'b1;
        ui_in     = 8'h5A;
        if (k == 0) check({tag, "_tx_in_ready"}, 32'(uio_out[1]), 32'd0, 0);
      end
      if (bp && k == 0) begin
        vcnt    = 0;
        changes = 0;
        first   = uo_out;
        repeat (20) begin
          @(negedge clk);
          if (uio_out[2]) vcnt++;
          if (uo_out != first) changes++;
        end
        check({tag, "_bp_valid_held"}, 32'(vcnt), 32'd20, 0);
        check({tag, "_bp_byte_stable"}, 32'(changes), 32'd0, 0);
      end
      b[k]      = uo_out;
      uio_in[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      uio_in[3] = 1'b0;
    end
    uio_in[0] = 1'b0;
    ui_in     = 8'h00;
    got_mag = {16'h0000, b[1], b[0]};
    got_ph  = {b[5], b[4], b[3], b[2]};
    mag_e   = mag_exp_q.pop_front();
    ph_e    = ph_exp_q.pop_front();
    check({tag, "_mag"}, got_mag, mag_e, mtol);
    check({tag, "_phase"}, got_ph, ph_e, ptol);
    check({tag, "_back_to_rx"}, 32'(uio_out[1]), 32'd1, 0);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] mag_e, input logic [31:0] ph_e,
                         input int unsigned mtol, input int unsigned ptol,
                         input int gap, input bit bp, input bit poke);
    int lat;
    mag_exp_q.push_back(mag_e);
    ph_exp_q.push_back(ph_e);
    send_byte(x[7:0]);
    send_byte(x[15:8]);
    send_byte(y[7:0]);
    send_byte(y[15:8]);
    lat = 0;
    while (!uio_out[2] && lat < 200) begin
      if (lat == 5 && gap > 0) begin
        ena = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          lat++;
          check({tag, "_frozen_valid"}, 32'(uio_out[2]), 32'd0, 0);
        end
        ena = 1'b1;
      end else begin
        if (lat == 2) check({tag, "_uo_idle"}, 32'(uo_out), 32'd0, 0);
        if (poke) begin
          uio_in[0] = ~uio_in[0];
          ui_in     = 8'hA5;
          if (lat == 3) check({tag, "_calc_in_ready"}, 32'(uio_out[1]), 32'd0, 0);
        end
        @(negedge clk);
        lat++;
      end
    end
    uio_in[0] = 1'b0;
    ui_in     = 8'h00;
    check({tag, "_latency"}, 32'(lat), 32'(18 + gap), 0);
    recv(tag, mtol, ptol, bp, poke);
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(uio_out[1]), 32'd0, 0);
    check("rst_out_valid", 32'(uio_out[2]), 32'd0, 0);
    check("rst_uo_out", 32'(uo_out), 32'd0, 0);
    check("rst_uio_out", 32'(uio_out), 32'd0, 0);
    check("rst_uio_oe", 32'(uio_oe), 32'h06, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(uio_out[1]), 32'd1, 0);

    run_vec("v1",       16'h4E20, 16'h3A98, 32'h61A8,  32'h1A37_F5C2, 4, 1 << 20, 0, 1'b0, 1'b0);
    run_vec("x_axis",   16'h4000, 16'h0000, 32'h4000,  32'h0000_0000, 4, 1 << 20, 0, 1'b0, 1'b0);
    run_vec("y_axis",   16'h0000, 16'h4000, 32'h4000,  32'h4000_0000, 4, 1 << 20, 0, 1'b0, 1'b0);
    run_vec("neg_x",    16'hB1E0, 16'h0000, 32'd20000, 32'h8000_0000, 4, 1 << 20, 0, 1'b0, 1'b0);
    run_vec("zero",     16'h0000, 16'h0000, 32'd0,     32'h0000_0000, 0, 0,       0, 1'b0, 1'b0);
    run_vec("min_diag", 16'h8000, 16'h8000, 32'd46341, 32'hA000_0000, 4, 1 << 20, 0, 1'b0, 1'b0);
    run_vec("q4_small", 16'd100,  16'hFF9C, 32'd141,   32'hE000_0000, 4, 1 << 20, 0, 1'b0, 1'b0);
    run_vec("bp_poke",  16'h4E20, 16'h3A98, 32'h61A8,  32'h1A37_F5C2, 4, 1 << 20, 0, 1'b1, 1'b1);
    run_vec("post_poke", 16'h4000, 16'h0000, 32'h4000, 32'h0000_0000, 4, 1 << 20, 0, 1'b0, 1'b0);

    send_byte(8'h20);
    send_byte(8'h4E);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready_in_rst", 32'(uio_out[1]), 32'd0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(uio_out[1]), 32'd1, 0);
    check("abort_out_valid", 32'(uio_out[2]), 32'd0, 0);
    check("abort_uo_out", 32'(uo_out), 32'd0, 0);
    run_vec("after_abort", 16'h4E20, 16'h3A98, 32'h61A8, 32'h1A37_F5C2, 4, 1 << 20, 0, 1'b0, 1'b0);

    run_vec("ena_gap",  16'h4E20, 16'h3A98, 32'h61A8,  32'h1A37_F5C2, 4, 1 << 20, 10, 1'b0, 1'b0);
    check("end_uio_oe", 32'(uio_oe), 32'h06, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
